// File: rtl/cla_seq_adder_ctrl.sv
// Purpose: add/subtract WIDTH-bit operands through one shared 4-bit CLA slice, one nibble per cycle, LSB first.
// Latency: out_valid rises NIB cycles after the accepting edge; request spacing is at least NIB+2 cycles.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready. Macro CLA_SEQ_OVF_EN enables signed overflow.
module cla_seq_adder_ctrl #(
   parameter int WIDTH = 16            // multiple of 4, at least 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow
);

   localparam int NIB  = WIDTH / 4;
   localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIB - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q;
   logic [IDXW-1:0]  idx_q;
   logic             carry_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] sum_q;
   logic [WIDTH-1:0] sum_d;
   logic             cout_q;
   logic             out_valid_q;

   // Slice datapath signals
   logic [IDXW+1:0]  bit_base;
   logic [3:0]       nib_a;
   logic [3:0]       nib_b;
   logic [3:0]       slice_g;
   logic [3:0]       slice_p;
   logic [4:0]       slice_c;
   logic [3:0]       slice_s;
   logic             last_nib;
   logic             accept;

   // Subtract mode is fully captured at accept time by the inverted
   // operand and the forced carry-in, so no mode bit is kept afterwards.
   assign bit_base = {idx_q, 2'b00};
   assign last_nib = (idx_q == LAST_IDX);
   assign in_ready = (state_q == S_IDLE) && !rst;
   assign accept   = in_valid && in_ready;

   // Shared 4-bit carry-lookahead slice fed by the current nibble and the chained carry
   always_comb begin
      nib_a      = a_q[bit_base +: 4];
      nib_b      = b_q[bit_base +: 4];
      slice_g    = nib_a & nib_b;
      slice_p    = nib_a ^ nib_b;
      slice_c[0] = carry_q;
      slice_c[1] = slice_g[0]
                 | (slice_p[0] & slice_c[0]);
      slice_c[2] = slice_g[1]
                 | (slice_p[1] & slice_g[0])
                 | (slice_p[1] & slice_p[0] & slice_c[0]);
      slice_c[3] = slice_g[2]
                 | (slice_p[2] & slice_g[1])
                 | (slice_p[2] & slice_p[1] & slice_g[0])
                 | (slice_p[2] & slice_p[1] & slice_p[0] & slice_c[0]);
      slice_c[4] = slice_g[3]
                 | (slice_p[3] & slice_g[2])
                 | (slice_p[3] & slice_p[2] & slice_g[1])
                 | (slice_p[3] & slice_p[2] & slice_p[1] & slice_g[0])
                 | (slice_p[3] & slice_p[2] & slice_p[1] & slice_p[0] & slice_c[0]);
      slice_s    = slice_p ^ slice_c[3:0];
   end

   // Next result word: current sum with the active nibble replaced by the slice output
   always_comb begin
      sum_d = sum_q;
      sum_d[bit_base +: 4] = slice_s;
   end

   // Sequencer: accept in IDLE, one nibble per cycle in CALC, hold result in DONE
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         idx_q       <= '0;
         carry_q     <= 1'b0;
         a_q         <= '0;
         b_q         <= '0;
         sum_q       <= '0;
         cout_q      <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               out_valid_q <= 1'b0;
               if (accept) begin
                  a_q     <= op_a;
                  b_q     <= sub ? ~op_b : op_b;
                  // Two's complement subtract: a + ~b + 1; cin is ignored in that mode
                  carry_q <= sub | cin;
                  idx_q   <= '0;
                  sum_q   <= '0;
                  cout_q  <= 1'b0;
                  state_q <= S_CALC;
               end
            end
            S_CALC: begin
               sum_q   <= sum_d;
               carry_q <= slice_c[4];
               if (last_nib) begin
                  // The MSB carry leaves only via cout; it never re-enters bit 0
                  cout_q      <= slice_c[4];
                  idx_q       <= '0;
                  out_valid_q <= 1'b1;
                  state_q     <= S_DONE;
               end else begin
                  idx_q <= idx_q + 1'b1;
               end
            end
            S_DONE: begin
               // in_valid is deliberately ignored here; no same-cycle re-accept
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  state_q     <= S_IDLE;
               end
            end
            default: begin
               out_valid_q <= 1'b0;
               idx_q       <= '0;
               state_q     <= S_IDLE;
            end
         endcase
      end
   end

   assign sum       = sum_q;
   assign cout      = cout_q;
   assign out_valid = out_valid_q;

`ifdef CLA_SEQ_OVF_EN
   logic ovf_q;

   // Signed overflow: carry into the MSB differs from carry out of the MSB on the last nibble
   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_q <= 1'b0;
      end else if (accept) begin
         ovf_q <= 1'b0;
      end else if ((state_q == S_CALC) && last_nib) begin
         ovf_q <= slice_c[4] ^ slice_c[3];
      end
   end

   assign overflow = ovf_q;
`else
   assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_cla_seq_adder_ctrl.sv
// Directed bench for cla_seq_adder_ctrl (WIDTH=16): add, ripple, overflow, subtract,
// backpressure and mid-operation reset, each against hand-computed results.
module tb_cla_seq_adder_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] op_a;
   logic [15:0] op_b;
   logic        cin;
   logic        sub;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] sum;
   logic        cout;
   logic        overflow;

   int checks = 0;
   int errors = 0;

`ifdef CLA_SEQ_OVF_EN
   localparam logic OVF_ON = 1'b1;
`else
   localparam logic OVF_ON = 1'b0;
`endif

   cla_seq_adder_ctrl #(.WIDTH(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op_a      (op_a),
      .op_b      (op_b),
      .cin       (cin),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   // Advance one clock; sample 1 time unit after the rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Issue one request, verify NIB-cycle latency and the result, then drain it
   task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic c, input logic s, input logic [15:0] exp_sum,
                        input logic exp_cout, input logic exp_ovf);
      int n;
      check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      op_a     = a;
      op_b     = b;
      cin      = c;
      sub      = s;
      step();
      in_valid = 1'b0;
      op_a     = 16'hDEAD;
      op_b     = 16'hBEEF;
      cin      = ~c;
      sub      = ~s;
      n = 0;
      while (!out_valid && n < 20) begin
         step();
         n++;
      end
      check({tag, "_latency"}, 32'(n), 32'd4);
      check({tag, "_sum"}, 32'(sum), 32'(exp_sum));
      check({tag, "_cout"}, 32'(cout), 32'(exp_cout));
      check({tag, "_ovf"}, 32'(overflow), 32'(exp_ovf));
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check({tag, "_drain_vld"}, 32'(out_valid), 32'd0);
      check({tag, "_drain_rdy"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      logic [15:0] held_sum;
      logic        held_cout;
      int n;

      rst       = 1'b1;
      in_valid  = 1'b0;
      op_a      = '0;
      op_b      = '0;
      cin       = 1'b0;
      sub       = 1'b0;
      out_ready = 1'b0;

      // Reset state
      step();
      step();
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_sum", 32'(sum), 32'd0);
      check("rst_cout", 32'(cout), 32'd0);
      check("rst_ovf", 32'(overflow), 32'd0);
      rst = 1'b0;
      #1;
      check("post_rst_in_ready", 32'(in_ready), 32'd1);

      // Plain add
      do_op("add1", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
      // Full carry ripple through all nibbles
      do_op("ripple1", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
      do_op("ripple_cin", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
      // Carry-in used in add mode, crossing nibble boundaries
      do_op("add_cin", 16'h00FF, 16'h0F01, 1'b1, 1'b0, 16'h1001, 1'b0, 1'b0);
      // Signed overflow, positive and negative
      do_op("ovf_pos", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, OVF_ON);
      do_op("ovf_neg", 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, OVF_ON);
      // Subtract (cin ignored)
      do_op("sub_borrow", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
      do_op("sub_noborrow", 16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0);

      // Backpressure in DONE: 0x0100 + 0x0200 = 0x0300
      in_valid = 1'b1;
      op_a     = 16'h0100;
      op_b     = 16'h0200;
      cin      = 1'b0;
      sub      = 1'b0;
      step();
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 20) begin
         step();
         n++;
      end
      check("bp_latency", 32'(n), 32'd4);
      held_sum  = sum;
      held_cout = cout;
      check("bp_sum", 32'(held_sum), 32'h0300);
      for (int i = 0; i < 5; i++) begin
         in_valid = ~in_valid;
         op_a     = 16'(16'h1111 * (i + 1));
         op_b     = 16'(16'h2222 * (i + 1));
         sub      = ~sub;
         step();
         check("bp_hold_sum", 32'(sum), 32'(held_sum));
         check("bp_hold_cout", 32'(cout), 32'(held_cout));
         check("bp_hold_vld", 32'(out_valid), 32'd1);
         check("bp_in_ready", 32'(in_ready), 32'd0);
      end
      in_valid  = 1'b0;
      sub       = 1'b0;
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("bp_release_vld", 32'(out_valid), 32'd0);
      check("bp_release_rdy", 32'(in_ready), 32'd1);
      check("bp_release_sum", 32'(sum), 32'h0300);

      // Reset mid-CALC at nibble index 2
      in_valid = 1'b1;
      op_a     = 16'h1111;
      op_b     = 16'h2222;
      step();
      in_valid = 1'b0;
      step();
      step();
      check("midrst_calc_vld", 32'(out_valid), 32'd0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      #1;
      check("midrst_vld", 32'(out_valid), 32'd0);
      check("midrst_rdy", 32'(in_ready), 32'd1);
      check("midrst_sum", 32'(sum), 32'd0);
      for (int i = 0; i < 6; i++) begin
         step();
         check("midrst_stay_idle", 32'(out_valid), 32'd0);
      end
      do_op("after_rst", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
